// File: rtl/full_adder_pkg.sv
// Shared constants and the reference sum for the full_adder cell.
package full_adder_pkg;

  localparam int MAX_WIDTH = 64;

  // Reference {cout, s} = a + b + cin for an adder of the given width; result lives in bits [width:0].
  function automatic logic [MAX_WIDTH:0] ref_sum(
    input logic [MAX_WIDTH-1:0] a,
    input logic [MAX_WIDTH-1:0] b,
    input logic                 cin,
    input int unsigned          width
  );
    logic [MAX_WIDTH:0] mask;
    logic [MAX_WIDTH:0] r;
    if (width >= MAX_WIDTH) mask = '1;
    else                    mask = ((MAX_WIDTH+1)'(1) << width) - (MAX_WIDTH+1)'(1);
    r = {1'b0, a & mask[MAX_WIDTH-1:0]} + {1'b0, b & mask[MAX_WIDTH-1:0]} + (MAX_WIDTH+1)'(cin);
    return r;
  endfunction

endpackage

// File: rtl/full_adder_bit.sv
// 1-bit full adder cell, the ripple stage of full_adder.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
module full_adder_bit (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/full_adder.sv
// WIDTH-bit ripple-carry adder with combinational s/cout and an enabled, async-reset registered copy.
// Latency: s/cout zero cycles; s_q/cout_q one cycle after a clk edge with en=1.
// Backpressure: none; en=0 holds the registered copy.
module full_adder
  import full_adder_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic [WIDTH-1:0] s_q,
  output logic             cout_q
);

  logic [WIDTH:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    full_adder_bit u_bit (
      .a  (a[i]),
      .b  (b[i]),
      .ci (c[i]),
      .s  (s[i]),
      .co (c[i+1])
    );
  end

  assign cout = c[WIDTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q    <= '0;
      cout_q <= 1'b0;
    end else if (en) begin
      s_q    <= s;
      cout_q <= cout;
    end
  end

endmodule

// File: tb/tb_full_adder.sv
// Directed and random checks of full_adder at WIDTH 1, 8 and 16.
module tb_full_adder;
    import full_adder_pkg::*;

    logic clk = 1'b0;
    logic clk_on = 1'b0;
    logic rst;
    logic en;

    logic        a1, b1, cin1, s1, cout1, s_q1, cout_q1;
    logic [7:0]  a8, b8, s8, s_q8;
    logic        cin8, cout8, cout_q8;
    logic [15:0] a16, b16, s16, s_q16;
    logic        cin16, cout16, cout_q16;

    int n_tests = 0;
    int n_fail  = 0;

    logic [MAX_WIDTH:0] r;
    logic [16:0]        q16;
    logic [2:0]         sweep [8];
    logic [1:0]         sweep_exp [8];

    task automatic fail(input string tag);
        n_fail++;
        $error("FAIL %s", tag);
    endtask

    always #5 if (clk_on) clk = ~clk;

    full_adder #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .en(en), .a(a1), .b(b1), .cin(cin1),
        .s(s1), .cout(cout1), .s_q(s_q1), .cout_q(cout_q1)
    );

    full_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .en(en), .a(a8), .b(b8), .cin(cin8),
        .s(s8), .cout(cout8), .s_q(s_q8), .cout_q(cout_q8)
    );

    full_adder #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .en(en), .a(a16), .b(b16), .cin(cin16),
        .s(s16), .cout(cout16), .s_q(s_q16), .cout_q(cout_q16)
    );

    initial begin
        // {a,b,cin} -> {s,cout}
        sweep[0] = 3'b000; sweep_exp[0] = 2'b00;
        sweep[1] = 3'b001; sweep_exp[1] = 2'b10;
        sweep[2] = 3'b010; sweep_exp[2] = 2'b10;
        sweep[3] = 3'b011; sweep_exp[3] = 2'b01;
        sweep[4] = 3'b100; sweep_exp[4] = 2'b10;
        sweep[5] = 3'b101; sweep_exp[5] = 2'b01;
        sweep[6] = 3'b110; sweep_exp[6] = 2'b01;
        sweep[7] = 3'b111; sweep_exp[7] = 2'b11;

        rst = 1'b1; en = 1'b0;
        a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
        a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0;
        a16 = 16'h0000; b16 = 16'h0000; cin16 = 1'b0;
        #1;
        n_tests++; if (s_q1 !== 1'b0) fail("reset s_q1");
        n_tests++; if (cout_q1 !== 1'b0) fail("reset cout_q1");
        n_tests++; if (s_q8 !== 8'h00) fail("reset s_q8");
        n_tests++; if (cout_q8 !== 1'b0) fail("reset cout_q8");
        n_tests++; if (s_q16 !== 16'h0000) fail("reset s_q16");
        n_tests++; if (cout_q16 !== 1'b0) fail("reset cout_q16");

        // WIDTH=1 exhaustive sweep, clock stopped
        for (int i = 0; i < 8; i++) begin
            {a1, b1, cin1} = sweep[i];
            #10;
            n_tests++; if (s1 !== sweep_exp[i][1]) fail("sweep s1");
            n_tests++; if (cout1 !== sweep_exp[i][0]) fail("sweep cout1");
        end

        a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0; #10;
        n_tests++; if (s8 !== 8'h00) fail("zero s8");
        n_tests++; if (cout8 !== 1'b0) fail("zero cout8");
        a8 = 8'hFF; b8 = 8'h00; cin8 = 1'b1; #10;
        n_tests++; if (s8 !== 8'h00) fail("ripple s8");
        n_tests++; if (cout8 !== 1'b1) fail("ripple cout8");
        a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1; #10;
        n_tests++; if (s8 !== 8'hFF) fail("ones s8");
        n_tests++; if (cout8 !== 1'b1) fail("ones cout8");
        n_tests++; if (s_q8 !== 8'h00) fail("ones s_q8 in reset");

        // Registered path
        a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
        a8 = 8'h35; b8 = 8'h4A; cin8 = 1'b0;
        rst = 1'b0; en = 1'b1;
        #1;
        clk_on = 1'b1;
        @(posedge clk); #1;
        n_tests++; if (s_q8 !== 8'h7F) fail("load s_q8");
        n_tests++; if (cout_q8 !== 1'b0) fail("load cout_q8");

        @(negedge clk);
        en = 1'b0; a8 = 8'h80; b8 = 8'h90; cin8 = 1'b1;
        @(posedge clk); #1;
        n_tests++; if (s_q8 !== 8'h7F) fail("hold s_q8");
        n_tests++; if (cout_q8 !== 1'b0) fail("hold cout_q8");
        n_tests++; if (s8 !== 8'h11) fail("hold track s8");
        n_tests++; if (cout8 !== 1'b1) fail("hold track cout8");

        // Async reset between edges
        @(negedge clk); #2;
        rst = 1'b1; #1;
        n_tests++; if (s_q8 !== 8'h00) fail("async rst s_q8");
        n_tests++; if (cout_q8 !== 1'b0) fail("async rst cout_q8");
        n_tests++; if (s8 !== 8'h11) fail("rst comb s8");
        n_tests++; if (cout8 !== 1'b1) fail("rst comb cout8");

        @(negedge clk);
        a8 = 8'h35; b8 = 8'h4A; cin8 = 1'b0; en = 1'b1;
        @(posedge clk); #1;
        n_tests++; if (s_q8 !== 8'h00) fail("rst held s_q8");
        n_tests++; if (s8 !== 8'h7F) fail("rst comb s8 b");

        // Release on a rising edge: that edge must not load
        @(posedge clk); #0;
        rst = 1'b0; #1;
        n_tests++; if (s_q8 !== 8'h00) fail("release edge s_q8");
        @(posedge clk); #1;
        n_tests++; if (s_q8 !== 8'h7F) fail("after release s_q8");
        n_tests++; if (cout_q8 !== 1'b0) fail("after release cout_q8");

        // Random regression on WIDTH=16; dut16 inputs have been zero so its register holds 0
        q16 = 17'h0;
        n_tests++; if ({cout_q16, s_q16} !== q16) fail("pre-rand q16");
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            a16 = 16'($urandom);
            b16 = 16'($urandom);
            cin16 = 1'($urandom);
            en = ($urandom_range(0, 3) != 0);
            #1;
            r = ref_sum(64'(a16), 64'(b16), cin16, 16);
            n_tests++; if ({cout16, s16} !== r[16:0]) fail("rand comb");
            @(posedge clk); #1;
            if (en) q16 = r[16:0];
            n_tests++; if ({cout_q16, s_q16} !== q16) fail("rand reg");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
